mem_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/arb_pick.sv | 57 +++++
 rtl/mem_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master SRAM arbiter: grant-state encoding,
// master IDs and a helper that maps a grant state to its owning master.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        WR1  = 2'd3
    } arb_state_e;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

    // Owner of a grant state; only the IFU read belongs to master 0.
    function automatic logic grant_owner(input arb_state_e st);
        if (st == RD0) begin
            return M_IFU;
        end else begin
            return M_LSU;
        end
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational grant selector for mem_arbiter.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternate between masters on
// a simultaneous request; otherwise fixed m1 write > m1 read > m0 read).
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic       m0_req,
    input  logic       m1_rd_req,
    input  logic       m1_wr_req,
    input  logic       last_m,
    output arb_state_e next_state
);

    arb_state_e m1_pick_s;

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority ignores the grant history.
    logic unused_last_m;
    assign unused_last_m = last_m;
`endif

    // Choose the grant state for the requests seen this IDLE cycle
    always_comb begin
        next_state = IDLE;
        // Within the LSU a write always beats a read.
        if (m1_wr_req) begin
            m1_pick_s = WR1;
        end else begin
            m1_pick_s = RD1;
        end
`ifdef ARB_ROUND_ROBIN_EN
        if (m0_req && (m1_rd_req || m1_wr_req)) begin
            // Contention: the master that was not served last goes first.
            if (last_m == M_LSU) begin
                next_state = RD0;
            end else begin
                next_state = m1_pick_s;
            end
        end else if (m1_rd_req || m1_wr_req) begin
            next_state = m1_pick_s;
        end else if (m0_req) begin
            next_state = RD0;
        end else begin
            next_state = IDLE;
        end
`else
        if (m1_rd_req || m1_wr_req) begin
            next_state = m1_pick_s;
        end else if (m0_req) begin
            next_state = RD0;
        end else begin
            next_state = IDLE;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master / one-slave arbiter in front of the data SRAM. One transaction
// is granted at a time and held until its response handshake completes; the
// granted master's channels are routed straight through to the slave.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin between IFU and LSU).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    // master 0: instruction fetch, read only
    input  logic [AW-1:0]   m0_araddr,
    input  logic            m0_arvalid,
    output logic            m0_arready,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_rresp,
    output logic            m0_rvalid,
    input  logic            m0_rready,
    // master 1: load/store
    input  logic [AW-1:0]   m1_araddr,
    input  logic            m1_arvalid,
    output logic            m1_arready,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_rresp,
    output logic            m1_rvalid,
    input  logic            m1_rready,
    input  logic [AW-1:0]   m1_awaddr,
    input  logic            m1_awvalid,
    output logic            m1_awready,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    input  logic            m1_wvalid,
    output logic            m1_wready,
    output logic            m1_bresp,
    output logic            m1_bvalid,
    input  logic            m1_bready,
    // slave: data SRAM
    output logic [AW-1:0]   s_araddr,
    output logic            s_arvalid,
    input  logic            s_arready,
    input  logic [DW-1:0]   s_rdata,
    input  logic            s_rresp,
    input  logic            s_rvalid,
    output logic            s_rready,
    output logic [AW-1:0]   s_awaddr,
    output logic            s_awvalid,
    input  logic            s_awready,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wstrb,
    output logic            s_wvalid,
    input  logic            s_wready,
    input  logic            s_bresp,
    input  logic            s_bvalid,
    output logic            s_bready
);

    arb_state_e state_r;
    arb_state_e state_next_s;
    arb_state_e pick_s;
    logic       last_m_s;

    arb_pick u_pick (
        .m0_req     (m0_arvalid),
        .m1_rd_req  (m1_arvalid),
        .m1_wr_req  (m1_awvalid),
        .last_m     (last_m_s),
        .next_state (pick_s)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic last_m_r;

    // Remember which master received the most recent grant
    always_ff @(posedge clk) begin
        if (rst) begin
            last_m_r <= M_IFU;
        end else if ((state_r == IDLE) && (pick_s != IDLE)) begin
            last_m_r <= grant_owner(pick_s);
        end else begin
            last_m_r <= last_m_r;
        end
    end

    assign last_m_s = last_m_r;
`else
    assign last_m_s = M_IFU;
`endif

    // Grant state register; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Grant on a request from IDLE, release after the response handshake
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: state_next_s = pick_s;
            RD0: begin
                if (s_rvalid && m0_rready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RD0;
                end
            end
            RD1: begin
                if (s_rvalid && m1_rready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RD1;
                end
            end
            WR1: begin
                if (s_bvalid && m1_bready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WR1;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Route the granted master's channels to the slave; everything else idles at 0
    always_comb begin
        m0_arready = 1'b0;
        m0_rdata   = {DW{1'b0}};
        m0_rresp   = 1'b0;
        m0_rvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = {DW{1'b0}};
        m1_rresp   = 1'b0;
        m1_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bresp   = 1'b0;
        m1_bvalid  = 1'b0;
        s_araddr   = {AW{1'b0}};
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        s_awaddr   = {AW{1'b0}};
        s_awvalid  = 1'b0;
        s_wdata    = {DW{1'b0}};
        s_wstrb    = {(DW/8){1'b0}};
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        case (state_r)
            RD0: begin
                s_araddr   = m0_araddr;
                s_arvalid  = m0_arvalid;
                m0_arready = s_arready;
                m0_rdata   = s_rdata;
                m0_rresp   = s_rresp;
                m0_rvalid  = s_rvalid;
                s_rready   = m0_rready;
            end
            RD1: begin
                s_araddr   = m1_araddr;
                s_arvalid  = m1_arvalid;
                m1_arready = s_arready;
                m1_rdata   = s_rdata;
                m1_rresp   = s_rresp;
                m1_rvalid  = s_rvalid;
                s_rready   = m1_rready;
            end
            WR1: begin
                s_awaddr   = m1_awaddr;
                s_awvalid  = m1_awvalid;
                m1_awready = s_awready;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                s_wvalid   = m1_wvalid;
                m1_wready  = s_wready;
                m1_bresp   = s_bresp;
                m1_bvalid  = s_bvalid;
                s_bready   = m1_bready;
            end
            IDLE: begin
                s_arvalid = 1'b0;
            end
            default: begin
                s_arvalid = 1'b0;
            end
        endcase
    end

endmodule
